// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control for the 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic [4:0]  EX_rs,
    input  logic [4:0]  EX_rt,
    input  logic        EX_MemRead,
    input  logic        EX_branchTaken,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_dst,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_dst,
    input  logic        dm_ready,
    output logic        dm_req,
    output logic        PC_en,
    output logic        IF_ID_en,
    output logic        IF_ID_clear,
    output logic        ID_EX_en,
    output logic        ID_EX_clear,
    output logic        EX_MEM_en,
    output logic        MEM_WB_clear,
    output logic [1:0]  fwdA,
    output logic [1:0]  fwdB,
    output logic        mem_err,
    output logic [15:0] stall_cnt
);
    typedef enum logic {S_RUN, S_WAIT} state_t;

    state_t     state, state_nx;
    logic [7:0] wcnt, wcnt_nx;
    logic       mem_op, mem_stall, load_use, timeout, err_set;

    assign mem_op   = MEM_MemRead | MEM_MemWrite;
    assign timeout  = wcnt == 8'(WAIT_LIMIT);
    assign load_use = EX_MemRead && EX_rt != 5'd0 && (EX_rt == ID_rs || EX_rt == ID_rt);

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic mw, input logic [4:0] md,
                                           input logic ww, input logic [4:0] wd);
        return (mw && md != 5'd0 && md == src) ? 2'b10 :
               (ww && wd != 5'd0 && wd == src) ? 2'b01 : 2'b00;
    endfunction

    // state, wait counter, sticky error and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            wcnt      <= 8'd0;
            mem_err   <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            state     <= state_nx;
            wcnt      <= wcnt_nx;
            mem_err   <= mem_err | err_set;
            stall_cnt <= (!PC_en && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
        end
    end

    // memory-access sequencing: request once in RUN, then wait for ready or give up at the limit
    always_comb begin
        state_nx  = state;
        wcnt_nx   = wcnt;
        dm_req    = 1'b0;
        mem_stall = 1'b0;
        err_set   = 1'b0;
        if (state == S_RUN) begin
            dm_req = mem_op;
            if (mem_op && !dm_ready) begin
                mem_stall = 1'b1;
                state_nx  = S_WAIT;
                wcnt_nx   = 8'd1;
            end
        end else if (dm_ready) begin
            state_nx = S_RUN;
            wcnt_nx  = 8'd0;
        end else if (timeout) begin
            err_set  = 1'b1;
            state_nx = S_RUN;
            wcnt_nx  = 8'd0;
        end else begin
            mem_stall = 1'b1;
            wcnt_nx   = wcnt + 8'd1;
        end
    end

    // pipeline register controls; a memory stall freezes everything so a taken branch waits in EX
    always_comb begin
        PC_en        = !(mem_stall || (!EX_branchTaken && load_use));
        IF_ID_en     = PC_en;
        ID_EX_en     = !mem_stall;
        EX_MEM_en    = !mem_stall;
        MEM_WB_clear = mem_stall;
        IF_ID_clear  = !mem_stall && EX_branchTaken;
        ID_EX_clear  = !mem_stall && (EX_branchTaken || load_use);
        fwdA         = fwd_sel(EX_rs, MEM_RegWrite, MEM_dst, WB_RegWrite, WB_dst);
        fwdB         = fwd_sel(EX_rt, MEM_RegWrite, MEM_dst, WB_RegWrite, WB_dst);
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks against a behavioural model
module tb_pipe_hazard_ctrl;
    localparam int WL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] ID_rs = 0, ID_rt = 0, EX_rs = 0, EX_rt = 0, MEM_dst = 0, WB_dst = 0;
    logic EX_MemRead = 0, EX_branchTaken = 0, MEM_MemRead = 0, MEM_MemWrite = 0;
    logic MEM_RegWrite = 0, WB_RegWrite = 0, dm_ready = 0;
    logic dm_req, PC_en, IF_ID_en, IF_ID_clear, ID_EX_en, ID_EX_clear, EX_MEM_en, MEM_WB_clear, mem_err;
    logic [1:0] fwdA, fwdB;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad = 0;

    bit m_waiting = 0;
    int m_age = 0;
    bit m_err = 0;
    int m_stalls = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .EX_rs(EX_rs), .EX_rt(EX_rt),
        .EX_MemRead(EX_MemRead), .EX_branchTaken(EX_branchTaken), .MEM_MemRead(MEM_MemRead),
        .MEM_MemWrite(MEM_MemWrite), .MEM_RegWrite(MEM_RegWrite), .MEM_dst(MEM_dst),
        .WB_RegWrite(WB_RegWrite), .WB_dst(WB_dst), .dm_ready(dm_ready), .dm_req(dm_req),
        .PC_en(PC_en), .IF_ID_en(IF_ID_en), .IF_ID_clear(IF_ID_clear), .ID_EX_en(ID_EX_en),
        .ID_EX_clear(ID_EX_clear), .EX_MEM_en(EX_MEM_en), .MEM_WB_clear(MEM_WB_clear),
        .fwdA(fwdA), .fwdB(fwdB), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        logic [4:0] dst[2] = '{MEM_dst, WB_dst};
        bit         wr[2]  = '{MEM_RegWrite, WB_RegWrite};
        logic [1:0] code[2] = '{2'b10, 2'b01};
        for (int k = 0; k < 2; k++)
            if (wr[k] && dst[k] != 0 && dst[k] == src) return code[k];
        return 2'b00;
    endfunction

    task automatic idle();
        {ID_rs, ID_rt, EX_rs, EX_rt, MEM_dst, WB_dst} = '0;
        {EX_MemRead, EX_branchTaken, MEM_MemRead, MEM_MemWrite, MEM_RegWrite, WB_RegWrite, dm_ready} = '0;
        rst = 0;
    endtask

    task automatic step();
        bit access, gave_up, mstall, hazard, stop_pc, flush;
        @(negedge clk);
        access  = MEM_MemRead || MEM_MemWrite;
        gave_up = m_waiting && !dm_ready && m_age >= WL;
        mstall  = m_waiting ? (!dm_ready && !gave_up) : (access && !dm_ready);
        hazard  = EX_MemRead && EX_rt != 0 && (EX_rt == ID_rs || EX_rt == ID_rt);
        flush   = !mstall && EX_branchTaken;
        stop_pc = mstall || (!flush && hazard);
        chk("dm_req", dm_req, !m_waiting && access);
        chk("PC_en", PC_en, !stop_pc);
        chk("IF_ID_en", IF_ID_en, !stop_pc);
        chk("IF_ID_clear", IF_ID_clear, flush);
        chk("ID_EX_en", ID_EX_en, !mstall);
        chk("ID_EX_clear", ID_EX_clear, !mstall && (EX_branchTaken || hazard));
        chk("EX_MEM_en", EX_MEM_en, !mstall);
        chk("MEM_WB_clear", MEM_WB_clear, mstall);
        chk("fwdA", fwdA, ref_fwd(EX_rs));
        chk("fwdB", fwdB, ref_fwd(EX_rt));
        chk("mem_err", mem_err, m_err);
        chk("stall_cnt", stall_cnt, 16'(m_stalls));
        @(posedge clk);
        if (rst) begin
            m_waiting = 0; m_age = 0; m_err = 0; m_stalls = 0;
        end else begin
            if (stop_pc && m_stalls < 16'hFFFF) m_stalls++;
            if (gave_up) m_err = 1;
            if (m_waiting) begin
                m_age++;
                if (dm_ready || gave_up) m_waiting = 0;
            end else if (access && !dm_ready) begin
                m_waiting = 1;
                m_age = 1;
            end
        end
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        rst = 1; step(); step();
        idle(); step();
        chk("reset_pc_en", PC_en, 1'b1);
        chk("reset_stall_cnt", stall_cnt, 16'd0);
        EX_MemRead = 1; EX_rt = 8; ID_rs = 8; step();
        idle(); step();
        chk("load_use_count", stall_cnt, 16'd1);
        EX_MemRead = 1; EX_rt = 0; ID_rs = 0; ID_rt = 0; step();
        idle(); step();
        chk("rt_zero_no_stall", stall_cnt, 16'd1);
        MEM_MemRead = 1; step(); step(); step();
        dm_ready = 1; step();
        idle(); step();
        chk("mem_wait3_count", stall_cnt, 16'd4);
        EX_branchTaken = 1; EX_MemRead = 1; EX_rt = 3; ID_rt = 3; step();
        idle(); step();
        chk("branch_over_load_use", stall_cnt, 16'd4);
        MEM_MemWrite = 1; EX_branchTaken = 1; step(); step();
        dm_ready = 1; step();
        idle(); step();
        MEM_MemRead = 1; step(); step(); step(); step(); step();
        idle(); step();
        chk("timeout_err", mem_err, 1'b1);
        chk("timeout_count", stall_cnt, 16'd10);
        rst = 1; step();
        idle(); step();
        chk("err_cleared", mem_err, 1'b0);
        MEM_dst = 5; WB_dst = 5; EX_rs = 5; MEM_RegWrite = 1; WB_RegWrite = 1; step();
        MEM_RegWrite = 0; step();
        MEM_dst = 0; WB_dst = 0; MEM_RegWrite = 1; step();
        EX_rt = 7; WB_dst = 7; MEM_dst = 6; step();
        idle(); MEM_MemRead = 1; step(); step();
        rst = 1; step();
        idle(); step();
        dm_ready = 1; step();
        idle(); MEM_MemWrite = 1; dm_ready = 1; step();
        idle();
        for (int n = 0; n < 1500; n++) begin
            rst            = $urandom_range(0, 63) == 0;
            ID_rs          = 5'($urandom_range(0, 3));
            ID_rt          = 5'($urandom_range(0, 3));
            EX_rs          = 5'($urandom_range(0, 3));
            EX_rt          = 5'($urandom_range(0, 3));
            MEM_dst        = 5'($urandom_range(0, 3));
            WB_dst         = 5'($urandom_range(0, 3));
            EX_MemRead     = $urandom_range(0, 2) == 0;
            EX_branchTaken = $urandom_range(0, 4) == 0;
            MEM_MemRead    = $urandom_range(0, 3) == 0;
            MEM_MemWrite   = $urandom_range(0, 5) == 0;
            MEM_RegWrite   = 1'($urandom);
            WB_RegWrite    = 1'($urandom);
            dm_ready       = $urandom_range(0, 3) == 0;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
